// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: branch flush, load-use stall and multi-cycle EX occupancy.
// Control outputs are combinational from state and inputs; state, cnt and stall_cycles are registered.
module pipe_hazard_ctrl #(
  parameter int unsigned MULTI_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_multi,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_write,
  output logic        idex_bubble,
  output logic        exmem_bubble,
  output logic        busy,
  output logic [15:0] stall_cycles
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned STALL_W = 16;

  typedef enum logic {RUN, MULTI} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STALL_W-1:0] stall_q;
  logic               load_use;

  // Register 0 is never a real destination, so it cannot create a dependency.
  assign load_use = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_write && (stall_q != {STALL_W{1'b1}})) begin
        stall_q <= stall_q + STALL_W'(1);
      end
    end
  end

  // Next-state and control decode; reset forces the free-running defaults.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    busy         = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else if (id_multi) begin
            state_d = MULTI;
            cnt_d   = CNT_W'(MULTI_LAT - 1);
          end
        end
        MULTI: begin
          busy         = 1'b1;
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_bubble = 1'b1;
          // Leave after MULTI_LAT-1 cycles so the op occupies EX for MULTI_LAT cycles.
          if (cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign stall_cycles = stall_q;

endmodule
